// File: rtl/intr_ctrl_pkg.sv
// Shared encodings for the prioritised interrupt controller: FSM states,
// arbitration modes, error codes and default bus frame codes.
package intr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      TX   = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      MODE_POLL   = 2'b00,
      MODE_FIXED  = 2'b01,
      MODE_ROT    = 2'b10,
      MODE_FIXED2 = 2'b11
   } mode_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] ERR_BAD_DONE = 2'b10;

   localparam logic [4:0] TX_CODE_DEF   = 5'b01011;
   localparam logic [4:0] DONE_CODE_DEF = 5'b10100;

endpackage

// File: rtl/intr_prio_arbiter.sv
// Combinational find-first-set over the request vector, searching upward
// from a start pointer with wrap-around.
module intr_prio_arbiter
   import intr_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [ID_W-1:0]    start,
   output logic               hit,
   output logic [ID_W-1:0]    id
);

   logic [ID_W-1:0] idx;

   // Walk offsets from far to near so the nearest set bit is written last.
   always_comb begin
      hit = 1'b0;
      id  = '0;
      idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         idx = start + ID_W'(i);
         if (req[idx]) begin
            hit = 1'b1;
            id  = idx;
         end
      end
   end

endmodule

// File: rtl/intr_ctrl_prio.sv
// Interrupt controller with polling / fixed / rotating arbitration, masking,
// edge or level sensing, and an ack timeout on the intr_out/intr_in handshake.
module intr_ctrl_prio
   import intr_ctrl_pkg::*;
#(
   parameter int                    NUM_SRC   = 8,
   parameter int                    ID_W      = $clog2(NUM_SRC),
   parameter int                    BUS_W     = 8,
   parameter logic [BUS_W-ID_W-1:0] TX_CODE   = TX_CODE_DEF,
   parameter logic [BUS_W-ID_W-1:0] DONE_CODE = DONE_CODE_DEF,
   parameter int                    TIMEOUT   = 255
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] intr_rq,
   input  logic [NUM_SRC-1:0] intr_mask,
   input  logic [NUM_SRC-1:0] intr_edge,
   input  logic [1:0]         mode,
   input  logic               intr_in,
   inout  wire  [BUS_W-1:0]   intr_bus,
   output logic               intr_out,
   output logic               bus_oe,
   output logic               busy,
   output logic               err_pulse,
   output logic [1:0]         err_code
);

   localparam int CNT_W = $clog2(TIMEOUT + 2);

   state_t             state;
   logic               intr_in_q;
   logic [NUM_SRC-1:0] rq_q;
   logic [NUM_SRC-1:0] pend_edge;
   logic [NUM_SRC-1:0] pend_clr;
   logic [ID_W-1:0]    scan_idx;
   logic [ID_W-1:0]    rot_ptr;
   logic [ID_W-1:0]    cur_id;
   logic [CNT_W-1:0]   tmo_cnt;
   logic               rearm;

   logic               ack;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] eligible;
   logic [ID_W-1:0]    arb_start;
   logic               arb_hit;
   logic [ID_W-1:0]    arb_id;
   logic               sel_hit;
   logic [ID_W-1:0]    sel_id;
   logic [CNT_W-1:0]   tmo_nxt;
   logic               tmo_hit;
   logic               done_ok;

   assign ack      = intr_in_q & ~intr_in;
   assign rise     = intr_rq & ~rq_q & intr_edge;
   assign pending  = (intr_edge & pend_edge) | (~intr_edge & intr_rq);
   assign eligible = pending & ~intr_mask;

   assign arb_start = (mode == MODE_ROT) ? rot_ptr : '0;

   intr_prio_arbiter #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_arb (
      .req   (eligible),
      .start (arb_start),
      .hit   (arb_hit),
      .id    (arb_id)
   );

   assign sel_hit = (mode == MODE_POLL) ? eligible[scan_idx] : arb_hit;
   assign sel_id  = (mode == MODE_POLL) ? scan_idx : arb_id;

   assign tmo_nxt = tmo_cnt + CNT_W'(1);
   assign tmo_hit = (TIMEOUT != 0) && (tmo_nxt == CNT_W'(TIMEOUT));
   assign done_ok = (intr_bus == {DONE_CODE, cur_id});

   // A fresh edge on the in-service source during the service keeps it pending.
   always_comb begin
      pend_clr = '0;
      if (state == DONE && ack && done_ok && intr_edge[cur_id] && !rearm)
         pend_clr[cur_id] = 1'b1;
   end

   assign intr_bus = bus_oe ? {TX_CODE, cur_id} : 'z;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         intr_in_q <= 1'b1;
         rq_q      <= '0;
         pend_edge <= '0;
         scan_idx  <= '0;
         rot_ptr   <= '0;
         cur_id    <= '0;
         tmo_cnt   <= '0;
         rearm     <= 1'b0;
         intr_out  <= 1'b0;
         bus_oe    <= 1'b0;
         err_pulse <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         intr_in_q <= intr_in;
         rq_q      <= intr_rq;
         pend_edge <= (pend_edge & ~pend_clr) | rise;
         err_pulse <= 1'b0;
         if (state != IDLE && rise[cur_id])
            rearm <= 1'b1;

         case (state)
            IDLE: begin
               if (sel_hit) begin
                  cur_id   <= sel_id;
                  intr_out <= 1'b1;
                  tmo_cnt  <= '0;
                  rearm    <= 1'b0;
                  state    <= REQ;
               end else if (mode == MODE_POLL) begin
                  scan_idx <= scan_idx + ID_W'(1);
               end
            end
            REQ: begin
               if (ack) begin
                  intr_out <= 1'b0;
                  bus_oe   <= 1'b1;
                  tmo_cnt  <= '0;
                  state    <= TX;
               end else if (tmo_hit) begin
                  intr_out  <= 1'b0;
                  bus_oe    <= 1'b0;
                  err_pulse <= 1'b1;
                  err_code  <= ERR_TIMEOUT;
                  state     <= IDLE;
               end else begin
                  tmo_cnt <= tmo_nxt;
               end
            end
            TX: begin
               if (ack) begin
                  bus_oe <= 1'b0;
                  state  <= DONE;
               end else if (tmo_hit) begin
                  intr_out  <= 1'b0;
                  bus_oe    <= 1'b0;
                  err_pulse <= 1'b1;
                  err_code  <= ERR_TIMEOUT;
                  state     <= IDLE;
               end else begin
                  tmo_cnt <= tmo_nxt;
               end
            end
            DONE: begin
               if (ack) begin
                  if (done_ok) begin
                     rot_ptr <= cur_id + ID_W'(1);
                     if (mode == MODE_POLL)
                        scan_idx <= cur_id + ID_W'(1);
                  end else begin
                     err_pulse <= 1'b1;
                     err_code  <= ERR_BAD_DONE;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_intr_ctrl_prio.sv
// Randomised and directed bench for intr_ctrl_prio: a processor model drives
// the handshake, a scoreboard checks every ID frame and error strobe.
module tb_intr_ctrl_prio;

   localparam logic [4:0] TXC = 5'b01011;
   localparam logic [4:0] DNC = 5'b10100;
   localparam logic [7:0] EV_FRAME = 8'h01;
   localparam logic [7:0] EV_ERR   = 8'h02;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] intr_rq = '0;
   logic [7:0] intr_mask = '0;
   logic [7:0] intr_edge = '0;
   logic [1:0] mode = 2'b01;
   logic       intr_in = 1'b1;
   wire  [7:0] intr_bus;
   logic       intr_out, bus_oe, busy, err_pulse;
   logic [1:0] err_code;

   logic       tb_oe = 1'b0;
   logic [7:0] tb_data = '0;
   assign intr_bus = tb_oe ? tb_data : 8'bz;

   always #5 clk = ~clk;

   intr_ctrl_prio #(.NUM_SRC(8), .BUS_W(8), .TIMEOUT(10)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .intr_rq   (intr_rq),
      .intr_mask (intr_mask),
      .intr_edge (intr_edge),
      .mode      (mode),
      .intr_in   (intr_in),
      .intr_bus  (intr_bus),
      .intr_out  (intr_out),
      .bus_oe    (bus_oe),
      .busy      (busy),
      .err_pulse (err_pulse),
      .err_code  (err_code)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] exp_q[$];

   // Reference model state: rotation pointer, polling position, edge latches.
   logic [2:0]  m_rot  = '0;
   logic [2:0]  m_scan = '0;
   logic [7:0]  m_pend = '0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   function automatic int first_from(logic [7:0] v, int start);
      for (int k = 0; k < 8; k++) begin
         int idx = (start + k) % 8;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // Scoreboard monitor: every new ID frame and every error strobe is an event.
   logic oe_q = 1'b0;
   always @(negedge clk) begin
      if (bus_oe && !oe_q) sb_check({EV_FRAME, intr_bus});
      if (err_pulse) sb_check({EV_ERR, 6'b0, err_code});
      oe_q <= bus_oe;
   end

   task automatic sb_check(input logic [15:0] got);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL sb_unexpected: got %h expected none", got);
      end else begin
         e = exp_q.pop_front();
         chk("sb_event", {16'h0, got}, {16'h0, e});
      end
   endtask

   task automatic reset_dut();
      reset_n   = 1'b0;
      intr_in   = 1'b1;
      tb_oe     = 1'b0;
      intr_rq   = '0;
      intr_mask = '0;
      intr_edge = '0;
      mode      = 2'b01;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      m_rot   = '0;
      m_scan  = '0;
      m_pend  = '0;
   endtask

   // One complete service; called at a negedge with the DUT idle.
   task automatic service(input logic [7:0] rq, input logic [7:0] msk,
                          input logic [1:0] md, input bit corrupt, input int pulse_src);
      logic [7:0] elig;
      int id, exp_lat, lat;
      intr_rq   = rq;
      intr_mask = msk;
      mode      = md;
      elig = ((intr_edge & m_pend) | (~intr_edge & rq)) & ~msk;
      if (md == 2'b00) begin
         id      = first_from(elig, int'(m_scan));
         exp_lat = 1 + ((id - int'(m_scan) + 8) % 8);
         m_scan  = id[2:0];
      end else if (md == 2'b10) begin
         id      = first_from(elig, int'(m_rot));
         exp_lat = 1;
      end else begin
         id      = first_from(elig, 0);
         exp_lat = 1;
      end
      exp_q.push_back({EV_FRAME, TXC, id[2:0]});
      lat = 0;
      while (!intr_out && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("req_latency", lat, exp_lat);
      if (!intr_out) return;
      intr_in = 1'b0; @(negedge clk); intr_in = 1'b1; @(negedge clk);
      if (pulse_src >= 0) begin
         intr_rq[pulse_src] = 1'b1;
         @(negedge clk);
         intr_rq[pulse_src] = rq[pulse_src];
         if (intr_edge[pulse_src]) m_pend[pulse_src] = 1'b1;
      end
      intr_in = 1'b0; @(negedge clk); intr_in = 1'b1; @(negedge clk);
      tb_data = corrupt ? {DNC, id[2:0] ^ 3'b111} : {DNC, id[2:0]};
      if (corrupt) exp_q.push_back({EV_ERR, 8'h02});
      tb_oe = 1'b1; intr_in = 1'b0;
      @(negedge clk);
      intr_in = 1'b1; tb_oe = 1'b0;
      chk("idle_after_done", busy, 0);
      if (!corrupt) begin
         if (intr_edge[id] && pulse_src != id) m_pend[id] = 1'b0;
         m_rot = 3'(id + 1);
         if (md == 2'b00) m_scan = 3'(id + 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt;
      logic [7:0] rq, msk;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_intr_out", intr_out, 0);
      chk("rst_bus_oe", bus_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_err_code", err_code, 0);
      reset_dut();

      // Fixed priority, level: ID 2 first, then ID 5
      service(8'h24, 8'h00, 2'b01, 1'b0, -1);
      service(8'h20, 8'h00, 2'b01, 1'b0, -1);

      // Rotating with 0x81 held: 0, 7, 0
      reset_dut();
      repeat (3) service(8'h81, 8'h00, 2'b10, 1'b0, -1);

      // Edge source 3: one pulse gives one service
      reset_dut();
      intr_edge = 8'h08;
      intr_rq = 8'h08; @(negedge clk); intr_rq = 8'h00;
      m_pend[3] = 1'b1;
      service(8'h00, 8'h00, 2'b01, 1'b0, -1);
      cnt = 0;
      repeat (30) begin @(negedge clk); if (intr_out || busy) cnt++; end
      chk("edge_once", cnt, 0);
      // A new edge during service re-arms the source
      intr_rq = 8'h08; @(negedge clk); intr_rq = 8'h00;
      m_pend[3] = 1'b1;
      service(8'h00, 8'h00, 2'b01, 1'b0, 3);
      service(8'h00, 8'h00, 2'b01, 1'b0, -1);
      cnt = 0;
      repeat (30) begin @(negedge clk); if (intr_out || busy) cnt++; end
      chk("edge_rearm_once", cnt, 0);

      // Full mask holds the block idle; unmasking bit 6 serves ID 6
      reset_dut();
      intr_rq = 8'hFF; intr_mask = 8'hFF;
      cnt = 0;
      repeat (100) begin @(negedge clk); if (intr_out || busy) cnt++; end
      chk("mask_hold", cnt, 0);
      service(8'hFF, 8'hBF, 2'b01, 1'b0, -1);

      // Bad done frame while serving ID 2, then the retained request
      reset_dut();
      service(8'h04, 8'h00, 2'b01, 1'b1, -1);
      chk("bad_done_code", err_code, 2'b10);
      service(8'h04, 8'h00, 2'b01, 1'b0, -1);

      // Timeout in REQ, then timeout in TX
      reset_dut();
      intr_rq = 8'h02;
      exp_q.push_back({EV_ERR, 8'h01});
      cnt = 0;
      while (!intr_out && cnt < 40) begin @(negedge clk); cnt++; end
      cnt = 0;
      while (intr_out && cnt < 40) begin cnt++; @(negedge clk); end
      chk("req_timeout_len", cnt, 10);
      chk("tmo_err_pulse", err_pulse, 1);
      chk("tmo_err_code", err_code, 2'b01);
      @(negedge clk);
      chk("tmo_pulse_width", err_pulse, 0);
      chk("tmo_rerequest", intr_out, 1);
      exp_q.push_back({EV_FRAME, TXC, 3'd1});
      exp_q.push_back({EV_ERR, 8'h01});
      intr_in = 1'b0; @(negedge clk); intr_in = 1'b1;
      cnt = 0;
      while (bus_oe && cnt < 40) begin cnt++; @(negedge clk); end
      chk("tx_timeout_len", cnt, 10);
      chk("tx_tmo_err_code", err_code, 2'b01);

      // Reset asserted while in TX aborts at once without an error
      reset_dut();
      intr_rq = 8'h04;
      exp_q.push_back({EV_FRAME, TXC, 3'd2});
      cnt = 0;
      while (!intr_out && cnt < 40) begin @(negedge clk); cnt++; end
      intr_in = 1'b0; @(negedge clk); intr_in = 1'b1;
      chk("tx_bus_oe", bus_oe, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_bus_oe", bus_oe, 0);
      chk("abort_intr_out", intr_out, 0);
      chk("abort_busy", busy, 0);
      chk("abort_err_pulse", err_pulse, 0);
      chk("abort_err_code", err_code, 0);
      @(negedge clk);
      reset_dut();

      // Randomised services across all modes, masks and corrupted done frames
      for (int n = 0; n < 60; n++) begin
         do begin
            rq  = 8'($urandom_range(1, 255));
            msk = 8'($urandom & $urandom);
         end while ((rq & ~msk) == 8'h00);
         service(rq, msk, 2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), -1);
      end

      repeat (5) @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/intr_ctrl_prio.md
Name: intr_ctrl_prio

Overview:
- Parametrised successor to the 8-source polling interrupt controller.
- Arbitrates NUM_SRC request lines with selectable mode: polling scan, fixed priority or rotating priority.
- Adds per-source mask, per-source edge/level sensing with pending latches, and an acknowledge timeout.
- Sits between the peripheral request lines and the processor, using the same intr_out/intr_in handshake and the same code+ID frames on the shared bidirectional intr_bus.

Parameters:
- NUM_SRC, 8: number of sources; power of two, 2..32.
- ID_W, $clog2(NUM_SRC): width of the source ID.
- BUS_W, 8: intr_bus width; must satisfy BUS_W > ID_W.
- TX_CODE, 5'b01011: upper BUS_W-ID_W bits of the controller-to-processor ID frame.
- DONE_CODE, 5'b10100: upper BUS_W-ID_W bits of the processor-to-controller ISR-done frame.
- TIMEOUT, 255: maximum cycles to wait for an ack in REQ or TX. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- intr_rq  in  NUM_SRC  interrupt request lines.
- intr_mask  in  NUM_SRC  1 = source masked.
- intr_edge  in  NUM_SRC  1 = rising-edge sensitive, 0 = level sensitive.
- mode  in  2  00 polling, 01 fixed priority, 10 rotating, 11 treated as fixed.
- intr_in  in  1  processor acknowledge; falling edge = ack.
- intr_bus  inout  BUS_W  bidirectional ID/done bus.
- intr_out  out  1  interrupt request to the processor.
- bus_oe  out  1  high while this block drives intr_bus.
- busy  out  1  high whenever state != IDLE.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  01 timeout, 10 bad done frame; holds until the next error.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; intr_out=0, bus_oe=0, intr_bus=Z, busy=0, err_pulse=0, err_code=00; pending=0, scan_idx=0, rot_ptr=0, cur_id=0, intr_in_q=1, timeout counter=0. A reset asserted mid-service aborts immediately with no error reported.
- Ack detection: ack = intr_in_q & ~intr_in, where intr_in_q is intr_in registered. A held-low intr_in counts as one ack only.
- Pending: an edge source sets pending[i] on the rising edge of intr_rq[i] (one-cycle sampled) and clears it only on a successful done for i. A level source uses pending[i] = intr_rq[i] directly.
- eligible = pending & ~intr_mask. Mask changes during service do not abort the current service.
- IDLE:
  - polling: test eligible[scan_idx] once per cycle. On a hit, cur_id=scan_idx. On a miss, scan_idx increments and wraps at NUM_SRC-1 -> 0.
  - fixed: cur_id = lowest-index eligible bit.
  - rotating: cur_id = first eligible bit searching upward from rot_ptr, with wrap.
  - On any hit: intr_out=1 next cycle, go to REQ, clear the timeout counter. If eligible is detected in cycle n, intr_out is high in cycle n+1.
- REQ: on ack, set intr_out=0, bus_oe=1, intr_bus={TX_CODE,cur_id}, go to TX.
- TX: on ack, set bus_oe=0 (bus released to Z), go to DONE.
- DONE: no timeout in this state. On ack, sample intr_bus in the same cycle:
  - {DONE_CODE,cur_id}: clear pending[cur_id] if that source is edge-sensitive; rot_ptr=cur_id+1 (wraps); in polling mode scan_idx=cur_id+1; go to IDLE.
  - Any other value: err_pulse=1, err_code=10, pending retained, go to IDLE.
- Timeout: in REQ or TX the counter increments each cycle without an ack. When it reaches TIMEOUT: intr_out=0, bus_oe=0, err_pulse=1, err_code=01, pending retained, go to IDLE.
- Same-cycle ack and timeout: ack wins.
- A new edge on the source currently in service during REQ/TX/DONE re-sets pending and is serviced again later.
- Arithmetic: all index arithmetic is ID_W bits with natural wrap.
- An all-ones mask keeps the block in IDLE. The polling scan keeps running.

Decomposition:
- Package intr_ctrl_pkg holds:
  - state encodings IDLE/REQ/TX/DONE;
  - mode encodings;
  - err_code values;
  - default TX_CODE/DONE_CODE.
- One sub-module, intr_prio_arbiter: combinational find-first-set over NUM_SRC bits with a start pointer, returning hit and ID. Fixed mode uses pointer 0; rotating mode uses rot_ptr.

Test Plan:
- Fixed mode, level intr_rq=8'h24 -> intr_out rises one cycle later, ID frame 8'h5A ({01011,010}). After done frame 8'hA2, return to IDLE; source 5 is served next with frame 8'h5D.
- Rotating mode, intr_rq=8'h81 held, three full services with correct done frames -> IDs served in order 0, 7, 0.
- Edge source 3, one pulse of intr_rq[3] -> exactly one service; pending[3] is 0 afterwards, and no second intr_out.
- intr_mask=8'hFF with intr_rq=8'hFF -> intr_out stays 0 for 100 cycles. Clearing mask bit 6 -> service of ID 6.
- TIMEOUT=10, no ack in REQ -> intr_out falls after 10 cycles, err_pulse for one cycle, err_code=01, source re-requested.
- Done frame 8'hA5 while serving ID 2 -> err_code=10, pending kept. reset_n pulsed low while in TX -> bus_oe=0 and intr_bus=Z immediately.
